// File: rtl/pipe_skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer_pkg
// Shared definitions for the two-entry skid buffer pipeline stage:
//   - state_t      : occupancy state encoding (EMPTY / BUSY / FULL), 2 bits
//   - STATE_WIDTH  : width of the state register
//   - transition   : names of the datapath transitions used to steer the
//                    register enables (load, flow, fill, drain, unload, dump)
// -----------------------------------------------------------------------------
package pipe_skid_buffer_pkg;

   localparam int STATE_WIDTH = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // no words held
      BUSY  = 2'd1,   // one word, in the main register
      FULL  = 2'd2    // two words, main plus skid register
   } state_t;

   localparam int TRANSITION_WIDTH = 3;

   localparam logic [2:0] TR_NONE   = 3'd0;  // nothing moves
   localparam logic [2:0] TR_LOAD   = 3'd1;  // EMPTY -> BUSY, main <- input
   localparam logic [2:0] TR_FLOW   = 3'd2;  // BUSY  -> BUSY, main <- input
   localparam logic [2:0] TR_FILL   = 3'd3;  // BUSY  -> FULL, skid <- input
   localparam logic [2:0] TR_DRAIN  = 3'd4;  // BUSY  -> EMPTY, main left stale
   localparam logic [2:0] TR_UNLOAD = 3'd5;  // FULL  -> BUSY, main <- skid
   localparam logic [2:0] TR_DUMP   = 3'd6;  // clear: everything discarded

endpackage

// File: rtl/pipe_skid_buffer_register_sync_clear.sv
// -----------------------------------------------------------------------------
// register_sync_clear
// Plain WORD_WIDTH-bit register with clock enable and a synchronous,
// active-high clear that loads RESET_VALUE. Clear wins over the enable.
// Ports:
//   clock        : rising-edge clock
//   clock_enable : load data_in when high
//   clear        : synchronous clear to RESET_VALUE
//   data_in      : next value
//   data_out     : registered value
// -----------------------------------------------------------------------------
module register_sync_clear #(
   parameter int                    WORD_WIDTH  = 1,
   parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  clock_enable,
   input  logic                  clear,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [WORD_WIDTH-1:0] data_out
);

   // Storage element: clear has priority over a load.
   always_ff @(posedge clock) begin
      if (clear) begin
         data_out <= RESET_VALUE;
      end else if (clock_enable) begin
         data_out <= data_in;
      end
   end

endmodule

// File: rtl/pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer
// Two-entry ready/valid pipeline stage (main register plus skid register).
// Both handshake directions are fully registered: input_ready and
// output_valid come straight from flops loaded from the next state, so there
// is no combinational path from input_valid/output_ready to any output.
// One transfer per cycle, one cycle of latency, strict FIFO order.
// Ports:
//   clock        : rising-edge clock
//   clear        : synchronous active-high reset, discards held words
//   input_valid  : upstream word valid
//   input_ready  : registered; stage accepts a word this cycle
//   input_data   : upstream word
//   output_valid : registered; output_data holds a valid word
//   output_ready : downstream accepts this cycle
//   output_data  : registered output word (main register)
// -----------------------------------------------------------------------------
module pipe_skid_buffer
   import pipe_skid_buffer_pkg::*;
#(
   parameter int WORD_WIDTH = 0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  input_valid,
   output logic                  input_ready,
   input  logic [WORD_WIDTH-1:0] input_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic [WORD_WIDTH-1:0] output_data
);

   logic                        insert_s;
   logic                        remove_s;
   logic [STATE_WIDTH-1:0]      state_q_s;
   state_t                      state_r;
   state_t                      state_next_s;
   logic [TRANSITION_WIDTH-1:0] transition_s;
   logic                        main_ce_s;
   logic                        skid_ce_s;
   logic                        main_from_skid_s;
   logic [WORD_WIDTH-1:0]       main_d_s;
   logic [WORD_WIDTH-1:0]       skid_r;
   logic                        input_ready_next_s;
   logic                        output_valid_next_s;

   // Handshakes use only the registered flags, so an unready side's
   // valid/ready is ignored automatically.
   assign insert_s = input_valid & input_ready;
   assign remove_s = output_valid & output_ready;
   assign state_r  = state_t'(state_q_s);

   // Classify this cycle's activity into one named transition.
   always_comb begin
      transition_s = TR_NONE;
      if (clear) begin
         transition_s = TR_DUMP;
      end else begin
         case (state_r)
            EMPTY: begin
               if (insert_s) begin
                  transition_s = TR_LOAD;
               end else begin
                  transition_s = TR_NONE;
               end
            end
            BUSY: begin
               if (insert_s && remove_s) begin
                  transition_s = TR_FLOW;
               end else if (insert_s) begin
                  transition_s = TR_FILL;
               end else if (remove_s) begin
                  transition_s = TR_DRAIN;
               end else begin
                  transition_s = TR_NONE;
               end
            end
            FULL: begin
               // input_ready is low here, so no insert can coincide.
               if (remove_s) begin
                  transition_s = TR_UNLOAD;
               end else begin
                  transition_s = TR_NONE;
               end
            end
            default: begin
               transition_s = TR_NONE;
            end
         endcase
      end
   end

   // Turn the transition into next state and register enables.
   always_comb begin
      state_next_s     = state_r;
      main_ce_s        = 1'b0;
      skid_ce_s        = 1'b0;
      main_from_skid_s = 1'b0;
      case (transition_s)
         TR_LOAD: begin
            state_next_s = BUSY;
            main_ce_s    = 1'b1;
         end
         TR_FLOW: begin
            state_next_s = BUSY;
            main_ce_s    = 1'b1;
         end
         TR_FILL: begin
            state_next_s = FULL;
            skid_ce_s    = 1'b1;
         end
         TR_DRAIN: begin
            // Main keeps its old word; output_valid going low marks it stale.
            state_next_s = EMPTY;
         end
         TR_UNLOAD: begin
            state_next_s     = BUSY;
            main_ce_s        = 1'b1;
            main_from_skid_s = 1'b1;
         end
         TR_DUMP: begin
            // The registers' own clear inputs do the actual discarding.
            state_next_s = EMPTY;
         end
         default: begin
            state_next_s = state_r;
         end
      endcase
   end

   // Main register source: the skid word on unload, otherwise the input.
   always_comb begin
      main_d_s = input_data;
      if (main_from_skid_s) begin
         main_d_s = skid_r;
      end else begin
         main_d_s = input_data;
      end
   end

   // Handshake flags are decoded from the next state and then registered.
   always_comb begin
      input_ready_next_s  = (state_next_s != FULL);
      output_valid_next_s = (state_next_s != EMPTY);
   end

   register_sync_clear #(
      .WORD_WIDTH  (WORD_WIDTH),
      .RESET_VALUE ('0)
   ) u_main_reg (
      .clock        (clock),
      .clock_enable (main_ce_s),
      .clear        (clear),
      .data_in      (main_d_s),
      .data_out     (output_data)
   );

   register_sync_clear #(
      .WORD_WIDTH  (WORD_WIDTH),
      .RESET_VALUE ('0)
   ) u_skid_reg (
      .clock        (clock),
      .clock_enable (skid_ce_s),
      .clear        (clear),
      .data_in      (input_data),
      .data_out     (skid_r)
   );

   register_sync_clear #(
      .WORD_WIDTH  (STATE_WIDTH),
      .RESET_VALUE (EMPTY)
   ) u_state_reg (
      .clock        (clock),
      .clock_enable (1'b1),
      .clear        (clear),
      .data_in      (state_next_s),
      .data_out     (state_q_s)
   );

   register_sync_clear #(
      .WORD_WIDTH  (1),
      .RESET_VALUE (1'b1)
   ) u_input_ready_reg (
      .clock        (clock),
      .clock_enable (1'b1),
      .clear        (clear),
      .data_in      (input_ready_next_s),
      .data_out     (input_ready)
   );

   register_sync_clear #(
      .WORD_WIDTH  (1),
      .RESET_VALUE (1'b0)
   ) u_output_valid_reg (
      .clock        (clock),
      .clock_enable (1'b1),
      .clear        (clear),
      .data_in      (output_valid_next_s),
      .data_out     (output_valid)
   );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_buffer
// Self-checking bench for pipe_skid_buffer (WORD_WIDTH = 8).
// Reference model: a capacity-2 FIFO queue. Ready is "fewer than 2 words
// held", valid is "at least one word held", output_data is the queue head
// (or the last head after the queue empties, zero after clear).
// Scoreboard: accepted words are pushed on insert; a monitor pops and
// compares whenever the DUT presents a word that is taken downstream.
// Inputs change 1 time unit after a rising edge; checks run on falling edges.
// -----------------------------------------------------------------------------
module tb_pipe_skid_buffer;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         clear;
   logic         input_valid;
   logic         input_ready;
   logic [W-1:0] input_data;
   logic         output_valid;
   logic         output_ready;
   logic [W-1:0] output_data;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   logic [W-1:0] model_q[$];
   logic [W-1:0] model_last = '0;
   logic [W-1:0] sb_q[$];
   int           words_in  = 0;
   int           words_out = 0;

   pipe_skid_buffer #(.WORD_WIDTH(W)) dut (
      .clock        (clock),
      .clear        (clear),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model update on each rising edge (reads only bench-driven inputs).
   initial begin
      bit acc;
      bit rem;
      forever begin
         @(posedge clock);
         if (clear) begin
            words_in -= sb_q.size();
            model_q.delete();
            sb_q.delete();
            model_last = '0;
         end else begin
            acc = input_valid && (model_q.size() < 2);
            rem = output_ready && (model_q.size() > 0);
            if (rem) void'(model_q.pop_front());
            if (acc) begin
               model_q.push_back(input_data);
               sb_q.push_back(input_data);
               words_in++;
            end
            if (model_q.size() > 0) model_last = model_q[0];
         end
      end
   end

   // Monitor: flags/data against the model, removed words against the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         if (check_en) begin
            check("input_ready",  {31'd0, input_ready},  {31'd0, model_q.size() < 2});
            check("output_valid", {31'd0, output_valid}, {31'd0, model_q.size() > 0});
            check("output_data",  {24'd0, output_data},  {24'd0, model_last});
            if (output_valid && output_ready && !clear) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_underflow actual=word_out expected=no_word at %0t", $time);
               end else begin
                  words_out++;
                  check("sb_order", {24'd0, output_data}, {24'd0, sb_q.pop_front()});
               end
            end
         end
      end
   end

   // Directed and random stimulus.
   initial begin
      clear        = 1'b1;
      input_valid  = 1'b1;
      input_data   = 8'hAA;
      output_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      clear       = 1'b0;
      input_valid = 1'b0;
      input_data  = 8'h00;
      check_en    = 1'b1;
      @(negedge clock);
      check("reset_ready", {31'd0, input_ready},  32'd1);
      check("reset_valid", {31'd0, output_valid}, 32'd0);
      check("reset_data",  {24'd0, output_data},  32'h00);

      // Single pass
      @(posedge clock); #1;
      input_valid = 1'b1; input_data = 8'h11; output_ready = 1'b1;
      @(posedge clock); #1;
      input_valid = 1'b0;
      @(negedge clock);
      check("single_valid", {31'd0, output_valid}, 32'd1);
      check("single_data",  {24'd0, output_data},  32'h11);
      @(negedge clock);
      check("single_gone",  {31'd0, output_valid}, 32'd0);

      // Streaming 0x00..0x0F back to back
      for (int i = 0; i < 16; i++) begin
         @(posedge clock); #1;
         check("stream_ready", {31'd0, input_ready}, 32'd1);
         if (i > 0) begin
            check("stream_data", {24'd0, output_data}, i - 1);
         end else begin
            check("stream_first_valid", {31'd0, output_valid}, 32'd0);
         end
         input_valid = 1'b1;
         input_data  = 8'(i);
      end
      @(posedge clock); #1;
      input_valid = 1'b0;
      check("stream_tail", {24'd0, output_data}, 32'h0F);
      @(posedge clock); #1;

      // Backpressure
      output_ready = 1'b0; input_valid = 1'b1; input_data = 8'h21;
      @(posedge clock); #1;
      input_data = 8'h22;
      @(posedge clock); #1;
      input_data = 8'h23;
      check("bp_ready_low", {31'd0, input_ready}, 32'd0);
      check("bp_head",      {24'd0, output_data}, 32'h21);
      repeat (3) begin
         @(posedge clock); #1;
         check("bp_hold_ready", {31'd0, input_ready}, 32'd0);
         check("bp_hold_data",  {24'd0, output_data}, 32'h21);
      end
      output_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_ready_back", {31'd0, input_ready}, 32'd1);
      check("bp_second",     {24'd0, output_data}, 32'h22);
      @(posedge clock); #1;
      input_valid = 1'b0;
      check("bp_third",      {24'd0, output_data}, 32'h23);
      @(posedge clock); #1;

      // Clear while FULL
      output_ready = 1'b0; input_valid = 1'b1; input_data = 8'h31;
      @(posedge clock); #1;
      input_data = 8'h32;
      @(posedge clock); #1;
      input_valid = 1'b0;
      check("clr_full_ready", {31'd0, input_ready}, 32'd0);
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      check("clr_valid", {31'd0, output_valid}, 32'd0);
      check("clr_ready", {31'd0, input_ready},  32'd1);
      check("clr_data",  {24'd0, output_data},  32'h00);
      input_valid = 1'b1; input_data = 8'h40; output_ready = 1'b1;
      @(posedge clock); #1;
      input_valid = 1'b0;
      check("post_clr_valid", {31'd0, output_valid}, 32'd1);
      check("post_clr_data",  {24'd0, output_data},  32'h40);

      // Random stress
      for (int c = 0; c < 10000; c++) begin
         @(posedge clock); #1;
         input_valid  = 1'($urandom_range(0, 1));
         output_ready = 1'($urandom_range(0, 1));
         input_data   = 8'($urandom);
      end

      // Drain and account for every word
      @(posedge clock); #1;
      input_valid  = 1'b0;
      output_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      check("drain_sb_empty", sb_q.size(), 32'd0);
      check("word_count",     words_out,   words_in);
      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
